// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the instruction-fetch / data-stage memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

    localparam int unsigned STARVE_LIMIT_DEF = 32'd3;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of consecutive fetch denials; at_limit forces the next fetch to win.
module arb_starve_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int unsigned CNT_W = (LIMIT < 32'd1) ? 32'd1 : $clog2(LIMIT + 32'd1);
    localparam logic [CNT_W-1:0] LIM_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;

    // next count: clear wins over increment, increment saturates at the limit
    always_comb begin
        cnt_next_s = cnt_r;
        if (clr) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else if (inc && (cnt_r != LIM_C)) begin
            cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // count register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

    assign at_limit = (cnt_r == LIM_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port synchronous memory: data stage has priority,
// fetch is forced through after STARVE_LIMIT consecutive denials; responses return one cycle later.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32'd32,
    parameter int unsigned DATA_WIDTH   = 32'd32,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_valid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic                  dm_gnt,
    output logic                  dm_valid,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    owner_e owner_r;
    owner_e owner_next_s;
    logic   if_gnt_s;
    logic   dm_gnt_s;
    logic   at_limit_s;
    logic   starve_inc_s;
    logic   starve_clr_s;

    // grant decision; held in reset so requests presented during reset are ignored
    always_comb begin
        if_gnt_s = 1'b0;
        dm_gnt_s = 1'b0;
        if (!reset_n) begin
            if_gnt_s = 1'b0;
            dm_gnt_s = 1'b0;
        end else if (dm_req && !(if_req && at_limit_s)) begin
            dm_gnt_s = 1'b1;
        end else if (if_req) begin
            if_gnt_s = 1'b1;
        end else begin
            if_gnt_s = 1'b0;
            dm_gnt_s = 1'b0;
        end
    end

    // memory command mux follows the winner in the same cycle
    always_comb begin
        mem_addr  = if_addr;
        mem_wdata = dm_wdata;
        if (dm_gnt_s) begin
            mem_addr = dm_addr;
        end else begin
            mem_addr = if_addr;
        end
    end

    assign if_gnt = if_gnt_s;
    assign dm_gnt = dm_gnt_s;
    assign mem_en = if_gnt_s | dm_gnt_s;
    assign mem_we = dm_gnt_s & dm_we;

    // every denied fetch cycle counts; a grant or an idle fetch side restarts the count
    assign starve_inc_s = if_req & ~if_gnt_s;
    assign starve_clr_s = ~starve_inc_s;

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (starve_inc_s),
        .clr      (starve_clr_s),
        .at_limit (at_limit_s)
    );

    // owner of the response returning next cycle
    always_comb begin
        owner_next_s = OWN_NONE;
        case ({dm_gnt_s, if_gnt_s})
            2'b10:   owner_next_s = OWN_DM;
            2'b01:   owner_next_s = OWN_IF;
            default: owner_next_s = OWN_NONE;
        endcase
    end

    // owner register; reset drops any response still in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_r <= OWN_NONE;
        end else begin
            owner_r <= owner_next_s;
        end
    end

    assign if_valid = (owner_r == OWN_IF);
    assign dm_valid = (owner_r == OWN_DM);
    assign if_rdata = mem_rdata;
    assign dm_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a one-cycle-latency behavioural memory.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_valid;
    logic [31:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        bd_we;
    logic [5:0]  bd_idx;
    logic [31:0] bd_data;
    logic [31:0] mem_a [0:63];

    int tests;
    int fails;
    int we_cnt;

    mem_port_arbiter #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .STARVE_LIMIT (3)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_valid  (dm_valid),
        .dm_rdata  (dm_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // single-port synchronous memory with a backdoor load port
    always @(posedge clk) begin
        if (bd_we) mem_a[bd_idx] <= bd_data;
        if (mem_en) begin
            if (mem_we) mem_a[mem_addr[7:2]] <= mem_wdata;
            else        mem_rdata <= mem_a[mem_addr[7:2]];
        end
    end

    // count accepted write strobes
    always @(posedge clk) begin
        if (reset_n && mem_en && mem_we) we_cnt <= we_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] pat;

    initial begin
        tests    = 0;
        fails    = 0;
        we_cnt   = 0;
        reset_n  = 1'b0;
        if_req   = 1'b0;
        if_addr  = 32'h0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = 32'h0;
        dm_wdata = 32'h0;
        bd_we    = 1'b0;
        bd_idx   = 6'd0;
        bd_data  = 32'h0;
        pat      = 6'b110111;

        // reset state, with requests present that must be ignored
        tick();
        bd_we = 1'b1; bd_idx = 6'd16; bd_data = 32'hDEADBEEF;
        if_req = 1'b1; if_addr = 32'h40; dm_req = 1'b1;
        #1;
        check("rst_if_gnt", if_gnt, 32'd0);
        check("rst_dm_gnt", dm_gnt, 32'd0);
        check("rst_mem_en", mem_en, 32'd0);
        check("rst_if_valid", if_valid, 32'd0);
        check("rst_dm_valid", dm_valid, 32'd0);
        tick();
        bd_we = 1'b0;
        dm_req = 1'b0;
        tick();

        // first cycle after release: fetch of 0x40
        reset_n = 1'b1;
        #1;
        check("f_if_gnt", if_gnt, 32'd1);
        check("f_dm_gnt", dm_gnt, 32'd0);
        check("f_mem_en", mem_en, 32'd1);
        check("f_mem_we", mem_we, 32'd0);
        check("f_mem_addr", mem_addr, 32'h40);
        tick();
        if_req = 1'b0;
        #1;
        check("f_if_valid", if_valid, 32'd1);
        check("f_if_rdata", if_rdata, 32'hDEADBEEF);
        check("f_dm_valid", dm_valid, 32'd0);
        tick();
        check("f_idle_valid", if_valid, 32'd0);
        check("f_idle_en", mem_en, 32'd0);

        // store 0x12345678 to 0x80, then fetch it back
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'h12345678;
        #1;
        check("w_dm_gnt", dm_gnt, 32'd1);
        check("w_mem_we", mem_we, 32'd1);
        check("w_mem_addr", mem_addr, 32'h80);
        check("w_mem_wdata", mem_wdata, 32'h12345678);
        tick();
        dm_req = 1'b0; dm_we = 1'b0;
        if_req = 1'b1; if_addr = 32'h80;
        #1;
        check("w_dm_valid", dm_valid, 32'd1);
        check("w_if_gnt", if_gnt, 32'd1);
        check("w_rd_mem_we", mem_we, 32'd0);
        tick();
        if_req = 1'b0;
        #1;
        check("w_if_valid", if_valid, 32'd1);
        check("w_if_rdata", if_rdata, 32'h12345678);
        check("w_dm_valid_off", dm_valid, 32'd0);
        check("w_we_count", we_cnt, 32'd1);
        tick();

        // contention: both held, expect DM,DM,DM,IF,DM,DM with back-to-back responses
        if_req = 1'b1; if_addr = 32'h40;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("c_dm_gnt%0d", i), dm_gnt, {31'd0, pat[i]});
            check($sformatf("c_if_gnt%0d", i), if_gnt, {31'd0, ~pat[i]});
            if (i > 0) begin
                check($sformatf("c_dm_valid%0d", i), dm_valid, {31'd0, pat[i-1]});
                check($sformatf("c_if_valid%0d", i), if_valid, {31'd0, ~pat[i-1]});
                check($sformatf("c_rdata%0d", i), mem_rdata,
                      pat[i-1] ? 32'h12345678 : 32'hDEADBEEF);
            end
            tick();
        end
        if_req = 1'b0; dm_req = 1'b0;
        #1;
        check("c_dm_valid_last", dm_valid, 32'd1);
        check("c_dm_rdata_last", dm_rdata, 32'h12345678);
        check("c_if_valid_last", if_valid, 32'd0);
        tick();

        // asynchronous reset while a data read is pending
        if_req = 1'b1; dm_req = 1'b1; dm_addr = 32'h80;
        tick();
        #1;
        check("r_dm_gnt", dm_gnt, 32'd1);
        check("r_owner_pre", dut.owner_r, {30'd0, OWN_DM});
        reset_n = 1'b0;
        #1;
        check("r_owner", dut.owner_r, {30'd0, OWN_NONE});
        check("r_starve", {31'd0, dut.u_starve.at_limit}, 32'd0);
        check("r_dm_valid", dm_valid, 32'd0);
        check("r_dm_gnt_off", dm_gnt, 32'd0);
        tick();
        check("r_dm_valid_hold", dm_valid, 32'd0);
        check("r_if_valid_hold", if_valid, 32'd0);
        if_req = 1'b0; dm_req = 1'b0;
        reset_n = 1'b1;
        tick();
        check("r_idle", mem_en, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: byte-address width of both requesters and the memory port.
REQ-002 Parameter DATA_WIDTH, default 32: word width.
REQ-003 Parameter STARVE_LIMIT, default 3: consecutive fetch denials before fetch is forced to win.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 if_req  input  1  instruction-fetch read request.
REQ-007 if_addr  input  ADDR_WIDTH  fetch byte address.
REQ-008 if_gnt  output  1  fetch request accepted this cycle.
REQ-009 if_valid  output  1  fetch data valid on if_rdata.
REQ-010 if_rdata  output  DATA_WIDTH  fetched word.
REQ-011 dm_req  input  1  data-stage access request.
REQ-012 dm_we  input  1  data access is a write.
REQ-013 dm_addr  input  ADDR_WIDTH  data byte address.
REQ-014 dm_wdata  input  DATA_WIDTH  store data.
REQ-015 dm_gnt  output  1  data request accepted this cycle.
REQ-016 dm_valid  output  1  data access complete; load data valid on dm_rdata.
REQ-017 dm_rdata  output  DATA_WIDTH  loaded word.
REQ-018 mem_en, mem_we  output  1 each  single-port memory enable and write strobe.
REQ-019 mem_addr  output  ADDR_WIDTH  memory byte address (word index taken from bits [indexwidth+1:2] by the memory).
REQ-020 mem_wdata  output  DATA_WIDTH  memory write data.
REQ-021 mem_rdata  input  DATA_WIDTH  memory read data, valid the cycle after a read.

Function
REQ-022 At most one of if_gnt/dm_gnt is high per cycle; mem_en equals their OR.
REQ-023 Grant is combinational from current requests and state; mem_addr/mem_we/mem_wdata are driven from the granted requester in the same cycle; mem_we = dm_gnt & dm_we.
REQ-024 Priority: dm wins when both request, unless starve_cnt == STARVE_LIMIT, in which case if wins.
REQ-025 starve_cnt increments (saturating at STARVE_LIMIT) each cycle if_req is high and if_gnt low; clears on if_gnt or when if_req is low.
REQ-026 Owner register (states NONE, IF, DM) records the granted requester each cycle; NONE when no grant.
REQ-027 Latency: exactly 1 cycle; if_valid = (owner==IF), dm_valid = (owner==DM); valid pulses once per grant, including writes (ack).
REQ-028 if_rdata/dm_rdata pass mem_rdata through; value is don't-care when the matching valid is low.
REQ-029 Back-to-back grants allowed every cycle; no bubble inserted on owner change.
REQ-030 A request not granted must be held stable by the requester; the arbiter has no request buffering.
REQ-031 Requests during reset are ignored; first grant is possible in the first cycle after reset_n deasserts.

Reset
REQ-032 reset_n low asynchronously sets owner=NONE and starve_cnt=0; all outputs therefore read if_valid=0, dm_valid=0, and grants follow inputs only after release.
REQ-033 Reset asserted mid-access discards the pending response; no valid pulse is issued for it.

Structure
REQ-034 Shared package holds the owner enum (OWN_NONE, OWN_IF, OWN_DM) and the default STARVE_LIMIT constant.
REQ-035 One sub-module, arb_starve_counter: saturating counter with inc/clr inputs and at_limit output.

Verification
REQ-036 if_req only, addr 0x40, mem[16]=0xDEADBEEF -> if_gnt same cycle, if_valid next cycle with if_rdata=0xDEADBEEF.
REQ-037 dm_req write addr 0x80 data 0x12345678, then if_req read 0x80 -> mem_we=1 once, dm_valid next cycle, then if_rdata=0x12345678.
REQ-038 if_req and dm_req held high 6 cycles, STARVE_LIMIT=3 -> grant pattern DM,DM,DM,IF,DM,DM.
REQ-039 Both requests in same cycle, alternating owners back-to-back -> one valid per cycle, no gap, correct data routed to each side.
REQ-040 reset_n pulled low the cycle after a dm grant -> dm_valid stays 0, starve_cnt=0, owner=NONE immediately (asynchronous).
